// File: rtl/demux_12.sv
// demux_12: splits an interleaved lane0/lane1 word stream into registered word pairs.
// Pairs are emitted one cycle after the lane 1 word is sampled.
module demux_12 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] data_out_0,
    output logic [WIDTH-1:0] data_out_1,
    output logic             valid_out,
    output logic [7:0]       pair_cnt,
    output logic             orphan
);
    localparam logic [0:0] EXPECT_0 = 1'b0;
    localparam logic [0:0] EXPECT_1 = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] hold_0_q, hold_0_d;
    logic [WIDTH-1:0] out_0_q, out_0_d;
    logic [WIDTH-1:0] out_1_q, out_1_d;
    logic             valid_q, valid_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             orphan_q, orphan_d;
    logic             take, done;

    // sync_clr wins over valid_in: the word presented alongside it is dropped
    always_comb begin
        take     = valid_in && !sync_clr;
        done     = take && state_q == EXPECT_1;
        state_d  = sync_clr ? EXPECT_0 : (take ? ~state_q : state_q);
        hold_0_d = (take && state_q == EXPECT_0) ? data_in : hold_0_q;
        out_0_d  = done ? hold_0_q : out_0_q;
        out_1_d  = done ? data_in : out_1_q;
        valid_d  = done;
        cnt_d    = cnt_q + 8'(done);
        orphan_d = orphan_q | (sync_clr && state_q == EXPECT_1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EXPECT_0;
            hold_0_q <= '0;
            out_0_q  <= '0;
            out_1_q  <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_0_q <= hold_0_d;
            out_0_q  <= out_0_d;
            out_1_q  <= out_1_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            orphan_q <= orphan_d;
        end
    end

    assign data_out_0 = out_0_q;
    assign data_out_1 = out_1_q;
    assign valid_out  = valid_q;
    assign pair_cnt   = cnt_q;
    assign orphan     = orphan_q;
endmodule

// File: tb/tb_demux_12.sv
// tb_demux_12: directed self-checking bench for demux_12.
module tb_demux_12;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_in = 1'b0;
    logic [3:0] data_in = '0;
    logic       sync_clr = 1'b0;
    logic [3:0] data_out_0, data_out_1;
    logic       valid_out;
    logic [7:0] pair_cnt;
    logic       orphan;
    int total = 0;
    int bad = 0;

    demux_12 #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .sync_clr(sync_clr), .data_out_0(data_out_0), .data_out_1(data_out_1),
        .valid_out(valid_out), .pair_cnt(pair_cnt), .orphan(orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic sc, input logic [3:0] d);
        valid_in = v;
        sync_clr = sc;
        data_in  = d;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sync_clr = 1'b0;
    endtask

    task automatic outs(input string tag, input logic v, input logic [3:0] o0, input logic [3:0] o1,
                        input logic [7:0] c, input logic orph);
        chk({tag, ".valid"}, 32'(valid_out), 32'(v));
        chk({tag, ".out0"}, 32'(data_out_0), 32'(o0));
        chk({tag, ".out1"}, 32'(data_out_1), 32'(o1));
        chk({tag, ".cnt"}, 32'(pair_cnt), 32'(c));
        chk({tag, ".orphan"}, 32'(orphan), 32'(orph));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int adjacent;
        logic prev;
        // inputs ignored while reset is held
        step(1'b1, 1'b0, 4'hF);
        step(1'b1, 1'b1, 4'hE);
        outs("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        // basic pair
        step(1'b1, 1'b0, 4'h3);
        outs("basic_l0", 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 4'hA);
        outs("basic_pair", 1, 4'h3, 4'hA, 1, 0);
        step(1'b0, 1'b0, 4'h0);
        outs("basic_after", 0, 4'h3, 4'hA, 1, 0);
        // gap within a pair
        step(1'b1, 1'b0, 4'h5);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'hF);
            outs("gap_idle", 0, 4'h3, 4'hA, 1, 0);
        end
        step(1'b1, 1'b0, 4'h6);
        outs("gap_pair", 1, 4'h5, 4'h6, 2, 0);
        step(1'b0, 1'b0, 4'h0);
        chk("gap_after.valid", 32'(valid_out), 32'd0);
        // realign in EXPECT_1
        step(1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b1, 4'h2);
        outs("realign_clr", 0, 4'h5, 4'h6, 2, 1);
        step(1'b1, 1'b0, 4'h7);
        outs("realign_l0", 0, 4'h5, 4'h6, 2, 1);
        step(1'b1, 1'b0, 4'h8);
        outs("realign_pair", 1, 4'h7, 4'h8, 3, 1);
        // async reset mid-pair, between edges
        step(1'b1, 1'b0, 4'h9);
        #3;
        reset = 1'b1;
        #1;
        outs("async_rst", 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 4'hB);
        chk("post_rst_l0.valid", 32'(valid_out), 32'd0);
        step(1'b1, 1'b0, 4'hC);
        outs("post_rst_pair", 1, 4'hB, 4'hC, 1, 0);
        // sync_clr in EXPECT_0
        step(1'b0, 1'b1, 4'h0);
        outs("clr_e0", 0, 4'hB, 4'hC, 1, 0);
        step(1'b1, 1'b0, 4'hD);
        step(1'b1, 1'b0, 4'hE);
        outs("clr_e0_pair", 1, 4'hD, 4'hE, 2, 0);
        // wrap: 256 back-to-back pairs from a fresh reset
        reset = 1'b1;
        #2;
        reset = 1'b0;
        pulses = 0;
        adjacent = 0;
        prev = 1'b0;
        for (int i = 0; i < 512; i++) begin
            step(1'b1, 1'b0, 4'(i));
            if (valid_out) pulses++;
            if (valid_out && prev) adjacent++;
            prev = valid_out;
        end
        step(1'b0, 1'b0, 4'h0);
        if (valid_out && prev) adjacent++;
        chk("wrap.pulses", 32'(pulses), 32'd256);
        chk("wrap.adjacent", 32'(adjacent), 32'd0);
        chk("wrap.cnt", 32'(pair_cnt), 32'd0);
        chk("wrap.out0", 32'(data_out_0), 32'hE);
        chk("wrap.out1", 32'(data_out_1), 32'hF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
